// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with glitch rejection, parity/stop
//            checking and a valid/ready output with sticky overrun.
// Revision : 1.0
// ============================================================================
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_UART_RX,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   input  logic                 i_Ready,
   output logic                 o_Frame_Err,
   output logic                 o_Parity_Err,
   output logic                 o_Overrun,
   output logic                 o_Busy
);

   localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int               HALF       = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
   localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
   localparam logic             HAS_PARITY = (PARITY != 0);
   localparam logic             ODD_PARITY = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t               state, state_nx;
   logic                 rx_meta, rx_s;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [3:0]           bit_idx, bit_idx_nx;
   logic                 stop_idx, stop_idx_nx;
   logic [DATA_BITS-1:0] shift, shift_nx;
   logic                 par_err, par_err_nx;
   logic                 frm_err, frm_err_nx;
   logic [DATA_BITS-1:0] data_nx;
   logic                 valid_nx, fe_nx, pe_nx, ovr_nx;
   logic                 accept, frame_bad, frame_done, bit_tick;

   // Both flops reset high so a released reset never looks like a start edge
   // unless the line really is low.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_UART_RX;
         rx_s    <= rx_meta;
      end
   end

   assign accept    = o_Valid & i_Ready;
   assign frame_bad = frm_err | ~rx_s;
   assign bit_tick  = (cnt == BIT_LAST);
   assign o_Busy    = (state != S_IDLE);

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      bit_idx_nx  = bit_idx;
      stop_idx_nx = stop_idx;
      shift_nx    = shift;
      par_err_nx  = par_err;
      frm_err_nx  = frm_err;
      data_nx     = o_Data;
      valid_nx    = o_Valid;
      fe_nx       = o_Frame_Err;
      pe_nx       = o_Parity_Err;
      ovr_nx      = o_Overrun;
      frame_done  = 1'b0;

      if (accept) begin
         valid_nx = 1'b0;
         ovr_nx   = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nx = S_START;
               cnt_nx   = '0;
            end
         end
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx    = S_DATA;
                  bit_idx_nx  = '0;
                  stop_idx_nx = 1'b0;
                  par_err_nx  = 1'b0;
                  frm_err_nx  = 1'b0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               cnt_nx   = '0;
               shift_nx = {rx_s, shift[DATA_BITS-1:1]};
               if (bit_idx == DATA_LAST) begin
                  state_nx = HAS_PARITY ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_nx = bit_idx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               cnt_nx     = '0;
               par_err_nx = (^shift) ^ rx_s ^ ODD_PARITY;
               state_nx   = S_STOP;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               cnt_nx     = '0;
               frm_err_nx = frame_bad;
               if (stop_idx == STOP_LAST) begin
                  frame_done = 1'b1;
                  // A low stop bit may be a held-low line; wait for it to rise.
                  state_nx   = frame_bad ? S_BREAK : S_IDLE;
               end else begin
                  stop_idx_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // A word finishing on an accepting edge replaces the one being consumed.
      if (frame_done) begin
         if (!o_Valid || i_Ready) begin
            data_nx  = shift;
            fe_nx    = frame_bad;
            pe_nx    = par_err;
            valid_nx = 1'b1;
         end else begin
            ovr_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         stop_idx     <= 1'b0;
         shift        <= '0;
         par_err      <= 1'b0;
         frm_err      <= 1'b0;
         o_Data       <= '0;
         o_Valid      <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Overrun    <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         bit_idx      <= bit_idx_nx;
         stop_idx     <= stop_idx_nx;
         shift        <= shift_nx;
         par_err      <= par_err_nx;
         frm_err      <= frm_err_nx;
         o_Data       <= data_nx;
         o_Valid      <= valid_nx;
         o_Frame_Err  <= fe_nx;
         o_Parity_Err <= pe_nx;
         o_Overrun    <= ovr_nx;
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation serial-to-parallel front end for the design's UART links. It synchronises the asynchronous RX line, rejects start-bit glitches, and supports configurable data width, parity and stop bits. Received words go out on a valid/ready handshake with per-word framing/parity status and a sticky overrun flag. It sits between the RX pin and any byte-consuming logic (FIFO, command decoder).

## Interface
- CLKS_PER_BIT, 217, i_Clk cycles per bit period; legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- i_Clk  in  1  single system clock; all logic on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_UART_RX  in  1  asynchronous serial input; idles high.
- o_Data  out  DATA_BITS  received word, LSB = first data bit on the line; held while o_Valid=1.
- o_Valid  out  1  word available; stays high until accepted.
- i_Ready  in  1  consumer accepts the word when o_Valid & i_Ready are high on the same edge.
- o_Frame_Err  out  1  qualifies o_Data: a stop bit was sampled low.
- o_Parity_Err  out  1  qualifies o_Data: parity mismatch; always 0 when PARITY=0.
- o_Overrun  out  1  sticky: a frame completed while o_Valid=1 and was dropped.
- o_Busy  out  1  high in any state other than IDLE.

## Operation
- Input path: 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised signal rx_s.
- Bit counter: width ceil(log2(CLKS_PER_BIT)). HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: wait for rx_s=0, then go to START with the counter cleared.
- START: count to HALF-1, then sample. If rx_s=1, it is a glitch: return to IDLE and output nothing. If rx_s=0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, shifting in LSB first, for DATA_BITS samples. Then go to PARITY if PARITY≠0, else STOP.
- PARITY: sample once after CLKS_PER_BIT cycles. Error if the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
- STOP: sample STOP_BITS times, CLKS_PER_BIT cycles apart. Any low sample sets the frame error for this word.
- After the last stop sample, the completed word is handled as follows.
  - If o_Valid=0, or o_Valid=1 with i_Ready=1 on the same edge: load o_Data, o_Frame_Err and o_Parity_Err, and set o_Valid.
  - Otherwise: drop the word, set o_Overrun, and keep the old word and its flags unchanged.
- Next state after the last stop sample: IDLE if all stop samples were high. On a frame error go to BREAK instead.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from being decoded as repeated zero frames.
- Handshake: o_Valid falls on the accepting edge unless a new word loads on that same edge. o_Overrun clears on any accepting edge. If an overrun and an accept occur on the same edge, the new word loads and o_Overrun stays 0.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE and the counters clear.
  - o_Data=0, o_Valid=0, o_Frame_Err=0, o_Parity_Err=0, o_Overrun=0, o_Busy=0.
  - The synchroniser flops go to 1.
  - The partial frame is discarded.
  - After reset is released, a line that is already low is treated as a new start edge.

## Timing
- Synchroniser latency: 2 cycles from a pin change to rx_s.
- Start sample: HALF cycles after the first cycle with rx_s=0.
- Each later sample: exactly CLKS_PER_BIT cycles after the previous one; there is no resynchronisation inside a frame.
- o_Valid rises 1 cycle after the final stop sample. Total from the first cycle with rx_s=0 to o_Valid: HALF + (DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: IDLE is entered on the cycle after the final stop sample. A start edge half a bit period later is therefore caught with no lost frame.
- Minimum accepted start pulse: HALF cycles of rx_s=0. Shorter low pulses are rejected.
- o_Busy deasserts on the cycle IDLE is entered.

## Test plan
- Default parameters at CLKS_PER_BIT=16: send 0xA5, 8N1, with i_Ready=1. Required: o_Data=0xA5, o_Valid high for 1 cycle, both error flags 0, o_Valid at the cycle predicted by the Timing formula.
- Glitch: a 5-cycle low pulse on i_UART_RX with CLKS_PER_BIT=16. Required: o_Valid stays 0, o_Busy returns to 0, and the next valid frame 0x3C decodes correctly.
- PARITY=2, DATA_BITS=7: send 0x55 with correct parity, then with inverted parity. Required: o_Parity_Err=0 on the first word and 1 on the second; data 0x55 both times.
- STOP_BITS=2, second stop bit driven low: required o_Frame_Err=1 with o_Data still correct. Then hold the line low for 3 frame times: required no further o_Valid until the line returns high and a new frame arrives.
- Overrun: i_Ready=0; send 0x11 then 0x22 back-to-back. Required: o_Data=0x11 remains held and o_Overrun=1. Pulse i_Ready: required o_Valid=0 and o_Overrun=0.
- Reset mid-frame: assert i_Rst_n=0 during data bit 4, release, then send 0x81. Required: every output is 0 during reset, and exactly one word 0x81 is received afterwards.
